// File: rtl/dpd_pkg.sv
// Shared constants and helpers for the DPD front end: default widths,
// vector sizing and the alpha-max-beta-min envelope shift amounts.
package dpd_pkg;
   localparam int          DATA_WIDTH_DEF   = 16;
   localparam int          MEMORY_DEPTH_DEF = 5;
   localparam logic [15:0] Q15_MAX          = 16'h7FFF;
   localparam int          ENV_SH_A         = 2;
   localparam int          ENV_SH_B         = 3;

   function automatic int out_dim(input int m);
      return 3*m + 3;
   endfunction
endpackage

// File: rtl/env_magnitude.sv
// Combinational envelope estimate: max(|I|,|Q|) + min/4 + min/8, saturated to
// the positive full scale. Also used by the feedback path.
module env_magnitude
   import dpd_pkg::*;
#(
   parameter int W = DATA_WIDTH_DEF
)(
   input  logic [W-1:0] i_i,
   input  logic [W-1:0] i_q,
   output logic [W-1:0] o_env
);
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0] w_ai, w_aq, w_mx, w_mn;
   logic [W:0]   w_sum;

   // Most-negative input has no positive twin, so pin it to full scale.
   function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
      if (x == MINV) return MAXV;
      return x[W-1] ? -x : x;
   endfunction

   always_comb begin
      w_ai  = sat_abs(i_i);
      w_aq  = sat_abs(i_q);
      w_mx  = (w_ai > w_aq) ? w_ai : w_aq;
      w_mn  = (w_ai > w_aq) ? w_aq : w_ai;
      w_sum = {1'b0, w_mx} + {1'b0, (w_mn >> ENV_SH_A)} + {1'b0, (w_mn >> ENV_SH_B)};
      o_env = (w_sum > {1'b0, MAXV}) ? MAXV : w_sum[W-1:0];
   end
endmodule

// File: rtl/mem_tap_assembler.sv
// Per-channel I/Q/envelope history and memory-aware feature vector assembly
// for time-interleaved channels, with a single back-pressured output register.
module mem_tap_assembler
   import dpd_pkg::*;
#(
   parameter int  DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int  MEMORY_DEPTH = MEMORY_DEPTH_DEF,
   parameter int  NUM_CH       = 2,
   parameter int  CH_W         = 1,
   localparam int OUTPUT_DIM   = out_dim(MEMORY_DEPTH)
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic [3:0]                       cfg_depth,
   input  logic                             cfg_zero_pad,
   input  logic                             flush,
   input  logic signed [DATA_WIDTH-1:0]     in_i,
   input  logic signed [DATA_WIDTH-1:0]     in_q,
   input  logic [CH_W-1:0]                  in_ch,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [DATA_WIDTH*OUTPUT_DIM-1:0] out_vector,
   output logic [CH_W-1:0]                  out_ch,
   output logic                             out_valid,
   input  logic                             out_ready
);
   localparam int          W   = DATA_WIDTH;
   localparam int          M   = MEMORY_DEPTH;
   localparam logic [3:0]  M4  = 4'(MEMORY_DEPTH);
   localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

   // Entry k holds sample n-1-k; the incoming sample completes the M+1 window.
   logic [W-1:0] r_hi [NUM_CH][M];
   logic [W-1:0] r_hq [NUM_CH][M];
   logic [W-1:0] r_he [NUM_CH][M];
   logic [3:0]   r_cnt [NUM_CH];

   logic [W*OUTPUT_DIM-1:0] r_vec, w_vec;
   logic [CH_W-1:0]         r_ch, w_ch;
   logic                    r_valid;
   logic                    w_accept, w_ch_ok, w_qual;
   logic [3:0]              w_depth, w_cnt;
   logic [W-1:0]            w_env;

   assign in_ready   = !r_valid || out_ready;
   assign w_accept   = in_valid && in_ready && !flush;
   assign w_ch_ok    = {1'b0, in_ch} < NCH;
   assign w_ch       = w_ch_ok ? in_ch : '0;
   assign w_depth    = (cfg_depth > M4) ? M4 : cfg_depth;
   assign w_cnt      = r_cnt[w_ch];
   assign w_qual     = w_ch_ok && ((w_cnt >= w_depth) || cfg_zero_pad);
   assign out_vector = r_vec;
   assign out_ch     = r_ch;
   assign out_valid  = r_valid;

   env_magnitude #(.W(W)) u_env (
      .i_i   (in_i),
      .i_q   (in_q),
      .o_env (w_env)
   );

   always_comb begin
      w_vec = '0;
      w_vec[0*W +: W] = in_i;
      w_vec[1*W +: W] = in_q;
      w_vec[2*W +: W] = w_env;
      // Taps beyond the active depth or not yet written stay zero.
      for (int k = 1; k <= M; k++) begin
         if (4'(k) <= w_depth && 4'(k) <= w_cnt) begin
            w_vec[(2+k)*W         +: W] = r_he[w_ch][k-1];
            w_vec[(3+M+2*(k-1))*W +: W] = r_hi[w_ch][k-1];
            w_vec[(4+M+2*(k-1))*W +: W] = r_hq[w_ch][k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_cnt[c] <= '0;
            for (int k = 0; k < M; k++) begin
               r_hi[c][k] <= '0;
               r_hq[c][k] <= '0;
               r_he[c][k] <= '0;
            end
         end
      end else if (flush) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_cnt[c] <= '0;
            for (int k = 0; k < M; k++) begin
               r_hi[c][k] <= '0;
               r_hq[c][k] <= '0;
               r_he[c][k] <= '0;
            end
         end
      end else if (w_accept && w_ch_ok) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
               r_hi[c][0] <= in_i;
               r_hq[c][0] <= in_q;
               r_he[c][0] <= w_env;
               for (int k = 1; k < M; k++) begin
                  r_hi[c][k] <= r_hi[c][k-1];
                  r_hq[c][k] <= r_hq[c][k-1];
                  r_he[c][k] <= r_he[c][k-1];
               end
               if (r_cnt[c] < M4) r_cnt[c] <= r_cnt[c] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_vec   <= '0;
         r_ch    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_vec   <= '0;
         r_ch    <= '0;
      end else if (w_accept && w_qual) begin
         r_valid <= 1'b1;
         r_vec   <= w_vec;
         r_ch    <= in_ch;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_tap_assembler.sv
// Directed bench for mem_tap_assembler: envelope, warm-up/layout, channel
// isolation, back-pressure, zero-pad/clamp, flush and asynchronous reset.
module tb_mem_tap_assembler;
   import dpd_pkg::*;

   localparam int W  = 16;
   localparam int M  = 5;
   localparam int OD = 3*M + 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        cfg_depth;
   logic              cfg_zero_pad;
   logic              flush;
   logic signed [W-1:0] in_i, in_q;
   logic [0:0]        in_ch;
   logic              in_valid;
   logic              in_ready;
   logic [W*OD-1:0]   out_vector;
   logic [0:0]        out_ch;
   logic              out_valid;
   logic              out_ready;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_tap_assembler #(.DATA_WIDTH(W), .MEMORY_DEPTH(M), .NUM_CH(2), .CH_W(1)) dut (
      .clk(clk), .rst(rst), .cfg_depth(cfg_depth), .cfg_zero_pad(cfg_zero_pad),
      .flush(flush), .in_i(in_i), .in_q(in_q), .in_ch(in_ch), .in_valid(in_valid),
      .in_ready(in_ready), .out_vector(out_vector), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   function automatic logic [W-1:0] elem(input int k);
      return out_vector[k*W +: W];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic ch, input logic [W-1:0] i, input logic [W-1:0] q);
      in_valid = 1'b1;
      in_ch    = ch;
      in_i     = i;
      in_q     = q;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      logic [W-1:0] env_tab [6];
      logic [W-1:0] orv;
      env_tab = '{16'd7, 16'd6, 16'd5, 16'd3, 16'd2, 16'd1};
      rst = 1'b1; cfg_depth = 4'd0; cfg_zero_pad = 1'b0; flush = 1'b0;
      in_i = '0; in_q = '0; in_ch = '0; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_vec0", {16'd0, elem(0)}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      tick();

      // Envelope, D=0
      send(1'b0, 16'h4000, 16'h4000);
      chk("env1_valid", {31'd0, out_valid}, 32'd1);
      chk("env1", {16'd0, elem(2)}, 32'h5800);
      chk("env1_i", {16'd0, elem(0)}, 32'h4000);
      send(1'b0, 16'h7FFF, 16'h7FFF);
      chk("env2", {16'd0, elem(2)}, {16'd0, Q15_MAX});
      chk("env2_d0_mask", {16'd0, elem(3)}, 32'd0);
      send(1'b0, 16'h8000, 16'h0000);
      chk("env3", {16'd0, elem(2)}, 32'h7FFF);
      tick();
      chk("env_drain", {31'd0, out_valid}, 32'd0);

      // Warm-up and layout, D=5
      do_flush();
      cfg_depth = 4'd5;
      for (int k = 1; k <= 5; k++) begin
         send(1'b0, 16'(k), 16'(-k));
         chk($sformatf("warm%0d_none", k), {31'd0, out_valid}, 32'd0);
      end
      send(1'b0, 16'd6, 16'(-6));
      chk("warm6_valid", {31'd0, out_valid}, 32'd1);
      chk("warm6_i0", {16'd0, elem(0)}, 32'd6);
      chk("warm6_q0", {16'd0, elem(1)}, {16'd0, 16'hFFFA});
      for (int k = 0; k <= 5; k++)
         chk($sformatf("warm6_env%0d", k), {16'd0, elem(2+k)}, {16'd0, env_tab[k]});
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("warm6_i%0d", k), {16'd0, elem(3+M+2*(k-1))}, 32'(6-k));
         chk($sformatf("warm6_q%0d", k), {16'd0, elem(4+M+2*(k-1))}, {16'd0, 16'(k-6)});
      end

      // Channel independence, D=2
      do_flush();
      cfg_depth = 4'd2;
      send(1'b0, 16'd10, 16'd0); chk("ci_a", {31'd0, out_valid}, 32'd0);
      send(1'b1, 16'd20, 16'd0); chk("ci_b", {31'd0, out_valid}, 32'd0);
      send(1'b0, 16'd11, 16'd0); chk("ci_c", {31'd0, out_valid}, 32'd0);
      send(1'b1, 16'd21, 16'd0); chk("ci_d", {31'd0, out_valid}, 32'd0);
      send(1'b0, 16'd12, 16'd0);
      chk("ci_ch0_valid", {31'd0, out_valid}, 32'd1);
      chk("ci_ch0_ch", {31'd0, out_ch}, 32'd0);
      chk("ci_ch0_i2", {16'd0, elem(3+M+2)}, 32'd10);
      send(1'b1, 16'd22, 16'd0);
      chk("ci_ch1_valid", {31'd0, out_valid}, 32'd1);
      chk("ci_ch1_ch", {31'd0, out_ch}, 32'd1);
      chk("ci_ch1_i0", {16'd0, elem(0)}, 32'd22);
      chk("ci_ch1_i1", {16'd0, elem(3+M)}, 32'd21);
      chk("ci_ch1_i2", {16'd0, elem(3+M+2)}, 32'd20);
      chk("ci_ch1_i3", {16'd0, elem(3+M+4)}, 32'd0);
      tick();
      chk("ci_drain", {31'd0, out_valid}, 32'd0);

      // Back-pressure, D=0
      do_flush();
      cfg_depth = 4'd0;
      out_ready = 1'b0;
      in_valid = 1'b1; in_ch = 1'b0; in_i = 16'd100; in_q = 16'd0;
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_first", {16'd0, elem(0)}, 32'd100);
      in_i = 16'd101;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp_ready%0d", c), {31'd0, in_ready}, 32'd0);
         tick();
         chk($sformatf("bp_hold%0d", c), {16'd0, elem(0)}, 32'd100);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_rel1", {16'd0, elem(0)}, 32'd101);
      chk("bp_rel1_valid", {31'd0, out_valid}, 32'd1);
      in_i = 16'd102;
      tick();
      chk("bp_rel2", {16'd0, elem(0)}, 32'd102);
      in_valid = 1'b0;
      tick();
      chk("bp_end", {31'd0, out_valid}, 32'd0);

      // Zero-pad and depth clamp
      do_flush();
      cfg_depth = 4'd9; cfg_zero_pad = 1'b1;
      send(1'b0, 16'h1000, 16'h0800);
      chk("zp_valid", {31'd0, out_valid}, 32'd1);
      chk("zp_i0", {16'd0, elem(0)}, 32'h1000);
      chk("zp_q0", {16'd0, elem(1)}, 32'h0800);
      chk("zp_env0", {16'd0, elem(2)}, 32'h1300);
      orv = '0;
      for (int k = 3; k < OD; k++) orv = orv | elem(k);
      chk("zp_rest_zero", {16'd0, orv}, 32'd0);
      send(1'b0, 16'h2000, 16'h0000);
      chk("zp2_env1", {16'd0, elem(3)}, 32'h1300);
      chk("zp2_i1", {16'd0, elem(3+M)}, 32'h1000);
      chk("zp2_q1", {16'd0, elem(4+M)}, 32'h0800);
      chk("zp2_i2", {16'd0, elem(3+M+2)}, 32'd0);
      do_flush();
      cfg_zero_pad = 1'b0;
      for (int k = 1; k <= 5; k++) send(1'b0, 16'(k), 16'd0);
      chk("clamp_5_none", {31'd0, out_valid}, 32'd0);
      send(1'b0, 16'd6, 16'd0);
      chk("clamp_6_valid", {31'd0, out_valid}, 32'd1);
      chk("clamp_i5", {16'd0, elem(3+M+8)}, 32'd1);

      // Flush with simultaneous input, D=2
      do_flush();
      cfg_depth = 4'd2;
      send(1'b0, 16'd1, 16'd0);
      send(1'b0, 16'd2, 16'd0);
      flush = 1'b1;
      send(1'b0, 16'd3, 16'd0);
      flush = 1'b0;
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      send(1'b0, 16'd4, 16'd0); chk("fl_a", {31'd0, out_valid}, 32'd0);
      send(1'b0, 16'd5, 16'd0); chk("fl_b", {31'd0, out_valid}, 32'd0);
      send(1'b0, 16'd6, 16'd0);
      chk("fl_out", {31'd0, out_valid}, 32'd1);
      chk("fl_i1", {16'd0, elem(3+M)}, 32'd5);
      chk("fl_i2", {16'd0, elem(3+M+2)}, 32'd4);
      out_ready = 1'b0;
      tick();
      chk("fl_pending", {31'd0, out_valid}, 32'd1);
      do_flush();
      chk("fl_prio", {31'd0, out_valid}, 32'd0);
      chk("fl_vec_clr", {16'd0, elem(0)}, 32'd0);
      out_ready = 1'b1;

      // Asynchronous reset mid-stream
      cfg_depth = 4'd0;
      send(1'b0, 16'd7, 16'd0);
      out_ready = 1'b0;
      chk("rs_pre", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rs_async_valid", {31'd0, out_valid}, 32'd0);
      chk("rs_async_vec", {16'd0, elem(0)}, 32'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      cfg_depth = 4'd1;
      send(1'b0, 16'd8, 16'd0);
      chk("rs_warm", {31'd0, out_valid}, 32'd0);
      send(1'b0, 16'd9, 16'd0);
      chk("rs_out", {31'd0, out_valid}, 32'd1);
      chk("rs_i1", {16'd0, elem(3+M)}, 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
